// File: rtl/sc_reg_serialin_pkg.sv
// Shared types and sizing helpers for the serial-in register front end.
// Optional parity stage is enabled by defining SC_REGSERIALIN_PARITY_EN.
package sc_reg_serialin_pkg;

    localparam int RegSERIALIN_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef SC_REGSERIALIN_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_LOAD   = 2'd3
    } regSerialInState_t;

    // Bit counter width; a one-bit word still needs a one-bit counter.
    function automatic int regSerialInCountWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sc_reg_serialin_if.sv
// Serial-in front-end bus: serial bit stream in, parallel load towards the general register.
// The error flag is only meaningful when SC_REGSERIALIN_PARITY_EN is defined.
interface sc_reg_serialin_if #(
    parameter int RegSERIALIN_DATAWIDTH = 8
);
    logic                             SC_RegSERIALIN_start_InLow;
    logic                             SC_RegSERIALIN_bitValid_InHigh;
    logic                             SC_RegSERIALIN_serial_In;
    logic [RegSERIALIN_DATAWIDTH-1:0] SC_RegSERIALIN_data_OutBUS;
    logic                             SC_RegSERIALIN_load_OutLow;
    logic                             SC_RegSERIALIN_busy_OutHigh;
    logic                             SC_RegSERIALIN_error_OutHigh;

    modport master (
        output SC_RegSERIALIN_start_InLow,
        output SC_RegSERIALIN_bitValid_InHigh,
        output SC_RegSERIALIN_serial_In,
        input  SC_RegSERIALIN_data_OutBUS,
        input  SC_RegSERIALIN_load_OutLow,
        input  SC_RegSERIALIN_busy_OutHigh,
        input  SC_RegSERIALIN_error_OutHigh
    );

    modport slave (
        input  SC_RegSERIALIN_start_InLow,
        input  SC_RegSERIALIN_bitValid_InHigh,
        input  SC_RegSERIALIN_serial_In,
        output SC_RegSERIALIN_data_OutBUS,
        output SC_RegSERIALIN_load_OutLow,
        output SC_RegSERIALIN_busy_OutHigh,
        output SC_RegSERIALIN_error_OutHigh
    );
endinterface

// File: rtl/sc_reg_serialin_counter.sv
// Received-bit counter: synchronous clear, count enable, flag on the last data bit position.
module sc_reg_serialin_counter
    import sc_reg_serialin_pkg::*;
#(
    parameter int RegSERIALIN_DATAWIDTH = RegSERIALIN_DEFAULT_WIDTH
) (
    input  logic SC_RegSERIALIN_CLOCK_50,
    input  logic SC_RegSERIALIN_RESET_InLow,
    input  logic counterClear,
    input  logic counterEnable,
    output logic counterTerminal
);
    localparam int CountW = regSerialInCountWidth(RegSERIALIN_DATAWIDTH);
    localparam logic [CountW-1:0] TermCount = CountW'(RegSERIALIN_DATAWIDTH - 1);

    logic [CountW-1:0] bitCount;

    always_ff @(posedge SC_RegSERIALIN_CLOCK_50 or negedge SC_RegSERIALIN_RESET_InLow) begin
        if (!SC_RegSERIALIN_RESET_InLow) begin
            bitCount <= '0;
        end else if (counterClear) begin
            bitCount <= '0;
        end else if (counterEnable) begin
            bitCount <= bitCount + 1'b1;
        end
    end

    assign counterTerminal = (bitCount == TermCount);

endmodule

// File: rtl/sc_reg_serialin.sv
// Serial-to-parallel front end for the general register: LSB-first shift-in, one-cycle load strobe.
// Define SC_REGSERIALIN_PARITY_EN to require a trailing even-parity bit per frame.
module sc_reg_serialin
    import sc_reg_serialin_pkg::*;
#(
    parameter int RegSERIALIN_DATAWIDTH = RegSERIALIN_DEFAULT_WIDTH
) (
    input logic                SC_RegSERIALIN_CLOCK_50,
    input logic                SC_RegSERIALIN_RESET_InLow,
    sc_reg_serialin_if.slave   serialBus
);
    regSerialInState_t                regState;
    logic [RegSERIALIN_DATAWIDTH-1:0] shiftReg;
    logic [RegSERIALIN_DATAWIDTH-1:0] dataReg;
    logic [RegSERIALIN_DATAWIDTH-1:0] shiftNext;
    logic [RegSERIALIN_DATAWIDTH:0]   shiftCat;
    logic                             loadReg;
    logic                             busyReg;
    logic                             startReq;
    logic                             bitValid;
    logic                             counterClear;
    logic                             counterEnable;
    logic                             counterTerminal;

    assign startReq = !serialBus.SC_RegSERIALIN_start_InLow;
    assign bitValid = serialBus.SC_RegSERIALIN_bitValid_InHigh;

    // New bit enters at the MSB so that after a full frame bit 0 holds the first bit received.
    assign shiftCat  = {serialBus.SC_RegSERIALIN_serial_In, shiftReg};
    assign shiftNext = shiftCat[RegSERIALIN_DATAWIDTH:1];

    // Start clears the count everywhere except LOAD, which ignores start.
    assign counterClear  = startReq && (regState != ST_LOAD);
    assign counterEnable = (regState == ST_SHIFT) && !startReq && bitValid;

    sc_reg_serialin_counter #(
        .RegSERIALIN_DATAWIDTH(RegSERIALIN_DATAWIDTH)
    ) u_counter (
        .SC_RegSERIALIN_CLOCK_50   (SC_RegSERIALIN_CLOCK_50),
        .SC_RegSERIALIN_RESET_InLow(SC_RegSERIALIN_RESET_InLow),
        .counterClear              (counterClear),
        .counterEnable             (counterEnable),
        .counterTerminal           (counterTerminal)
    );

`ifdef SC_REGSERIALIN_PARITY_EN
    logic errorReg;
`endif

    always_ff @(posedge SC_RegSERIALIN_CLOCK_50 or negedge SC_RegSERIALIN_RESET_InLow) begin
        if (!SC_RegSERIALIN_RESET_InLow) begin
            regState <= ST_IDLE;
            shiftReg <= '0;
            dataReg  <= '0;
            loadReg  <= 1'b1;
            busyReg  <= 1'b0;
`ifdef SC_REGSERIALIN_PARITY_EN
            errorReg <= 1'b0;
`endif
        end else begin
            case (regState)
                ST_IDLE: begin
                    if (startReq) begin
                        regState <= ST_SHIFT;
                        shiftReg <= '0;
                        busyReg  <= 1'b1;
`ifdef SC_REGSERIALIN_PARITY_EN
                        errorReg <= 1'b0;
`endif
                    end
                end
                ST_SHIFT: begin
                    // Restart beats a coincident valid bit; that bit is dropped.
                    if (startReq) begin
                        shiftReg <= '0;
                    end else if (bitValid) begin
                        shiftReg <= shiftNext;
                        if (counterTerminal) begin
`ifdef SC_REGSERIALIN_PARITY_EN
                            regState <= ST_PARITY;
`else
                            regState <= ST_LOAD;
                            dataReg  <= shiftNext;
                            loadReg  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef SC_REGSERIALIN_PARITY_EN
                ST_PARITY: begin
                    if (startReq) begin
                        regState <= ST_SHIFT;
                        shiftReg <= '0;
                    end else if (bitValid) begin
                        if ((^shiftReg ^ serialBus.SC_RegSERIALIN_serial_In) == 1'b0) begin
                            regState <= ST_LOAD;
                            dataReg  <= shiftReg;
                            loadReg  <= 1'b0;
                        end else begin
                            // Bad frame: drop it, keep the previous word, flag until next start.
                            regState <= ST_IDLE;
                            busyReg  <= 1'b0;
                            errorReg <= 1'b1;
                        end
                    end
                end
`endif
                ST_LOAD: begin
                    regState <= ST_IDLE;
                    loadReg  <= 1'b1;
                    busyReg  <= 1'b0;
                end
                default: begin
                    regState <= ST_IDLE;
                    loadReg  <= 1'b1;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

    assign serialBus.SC_RegSERIALIN_data_OutBUS  = dataReg;
    assign serialBus.SC_RegSERIALIN_load_OutLow  = loadReg;
    assign serialBus.SC_RegSERIALIN_busy_OutHigh = busyReg;
`ifdef SC_REGSERIALIN_PARITY_EN
    assign serialBus.SC_RegSERIALIN_error_OutHigh = errorReg;
`else
    assign serialBus.SC_RegSERIALIN_error_OutHigh = 1'b0;
`endif

endmodule

// File: tb/tb_sc_reg_serialin.sv
// Directed bench for sc_reg_serialin (DATAWIDTH=8); parity steps build when SC_REGSERIALIN_PARITY_EN is defined.
module tb_sc_reg_serialin;
    localparam int W = 8;

    logic clk  = 1'b0;
    logic rstN = 1'b1;
    int   nCompared   = 0;
    int   nMismatched = 0;

    sc_reg_serialin_if #(.RegSERIALIN_DATAWIDTH(W)) serialBus ();

    sc_reg_serialin #(.RegSERIALIN_DATAWIDTH(W)) dut (
        .SC_RegSERIALIN_CLOCK_50   (clk),
        .SC_RegSERIALIN_RESET_InLow(rstN),
        .serialBus                 (serialBus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutputs(input string tag, input logic [W-1:0] data, input logic load,
                                input logic busy, input logic err);
        check({tag, "_data"},  serialBus.SC_RegSERIALIN_data_OutBUS, data);
        check({tag, "_load"},  W'(serialBus.SC_RegSERIALIN_load_OutLow), W'(load));
        check({tag, "_busy"},  W'(serialBus.SC_RegSERIALIN_busy_OutHigh), W'(busy));
        check({tag, "_error"}, W'(serialBus.SC_RegSERIALIN_error_OutHigh), W'(err));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doStart(input string tag);
        serialBus.SC_RegSERIALIN_start_InLow = 1'b0;
        step();
        serialBus.SC_RegSERIALIN_start_InLow = 1'b1;
        check({tag, "_startBusy"}, W'(serialBus.SC_RegSERIALIN_busy_OutHigh), W'(1'b1));
        check({tag, "_startLoad"}, W'(serialBus.SC_RegSERIALIN_load_OutLow), W'(1'b1));
        check({tag, "_startErr"},  W'(serialBus.SC_RegSERIALIN_error_OutHigh), W'(1'b0));
    endtask

    // Sends bits 0..n-1 of v; every bit but a frame-completing last one must leave busy high, load idle.
    task automatic sendBits(input logic [W-1:0] v, input int n, input bit gaps,
                            input bit lastLoads, input string tag);
        for (int i = 0; i < n; i++) begin
            serialBus.SC_RegSERIALIN_serial_In       = v[i];
            serialBus.SC_RegSERIALIN_bitValid_InHigh = 1'b1;
            step();
            serialBus.SC_RegSERIALIN_bitValid_InHigh = 1'b0;
            if (!(lastLoads && i == n - 1)) begin
                check({tag, "_bitBusy"}, W'(serialBus.SC_RegSERIALIN_busy_OutHigh), W'(1'b1));
                check({tag, "_bitNoLoad"}, W'(serialBus.SC_RegSERIALIN_load_OutLow), W'(1'b1));
                if (gaps) begin
                    serialBus.SC_RegSERIALIN_serial_In = ~v[i];
                    step();
                    check({tag, "_gapBusy"}, W'(serialBus.SC_RegSERIALIN_busy_OutHigh), W'(1'b1));
                    check({tag, "_gapNoLoad"}, W'(serialBus.SC_RegSERIALIN_load_OutLow), W'(1'b1));
                end
            end
        end
    endtask

    task automatic sendFrameBits(input logic [W-1:0] v, input bit gaps, input string tag);
`ifdef SC_REGSERIALIN_PARITY_EN
        logic [W-1:0] parityWord;
        parityWord = {{(W-1){1'b0}}, ^v};
        sendBits(v, W, gaps, 1'b0, tag);
        sendBits(parityWord, 1, 1'b0, 1'b1, tag);
`else
        sendBits(v, W, gaps, 1'b1, tag);
`endif
    endtask

    // Called in the cycle right after the last bit was sampled: the load strobe must be there now, once.
    task automatic finishLoad(input logic [W-1:0] v, input string tag);
        checkOutputs({tag, "_loadCycle"}, v, 1'b0, 1'b1, 1'b0);
        step();
        checkOutputs({tag, "_afterLoad"}, v, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        serialBus.SC_RegSERIALIN_start_InLow     = 1'b1;
        serialBus.SC_RegSERIALIN_bitValid_InHigh = 1'b0;
        serialBus.SC_RegSERIALIN_serial_In       = 1'b0;

        // Reset values, asserted before any clock edge.
        #2 rstN = 1'b0;
        #1 checkOutputs("reset", 8'h00, 1'b1, 1'b0, 1'b0);
        step();
        step();
        rstN = 1'b1;
        checkOutputs("resetRelease", 8'h00, 1'b1, 1'b0, 1'b0);

        // 0xA5, valid every cycle.
        doStart("a5");
        sendFrameBits(8'hA5, 1'b0, "a5");
        finishLoad(8'hA5, "a5");

        // 0x3C, valid every other cycle.
        doStart("3c");
        sendFrameBits(8'h3C, 1'b1, "3c");
        finishLoad(8'h3C, "3c");

        // Four bits, then restart with a coincident valid bit, then 0x81.
        doStart("rs");
        sendBits(8'hFF, 4, 1'b0, 1'b0, "rsPre");
        serialBus.SC_RegSERIALIN_start_InLow     = 1'b0;
        serialBus.SC_RegSERIALIN_bitValid_InHigh = 1'b1;
        serialBus.SC_RegSERIALIN_serial_In       = 1'b1;
        step();
        serialBus.SC_RegSERIALIN_start_InLow     = 1'b1;
        serialBus.SC_RegSERIALIN_bitValid_InHigh = 1'b0;
        checkOutputs("rsCycle", 8'h3C, 1'b1, 1'b1, 1'b0);
        sendFrameBits(8'h81, 1'b0, "rs81");
        finishLoad(8'h81, "rs81");

        // Start held low during LOAD is ignored; FSM returns to IDLE, then accepts it.
        doStart("c3");
        sendFrameBits(8'hC3, 1'b0, "c3");
        checkOutputs("c3LoadCycle", 8'hC3, 1'b0, 1'b1, 1'b0);
        serialBus.SC_RegSERIALIN_start_InLow = 1'b0;
        step();
        checkOutputs("c3StartInLoad", 8'hC3, 1'b1, 1'b0, 1'b0);
        step();
        serialBus.SC_RegSERIALIN_start_InLow = 1'b1;
        checkOutputs("c3StartAfter", 8'hC3, 1'b1, 1'b1, 1'b0);
        sendFrameBits(8'h96, 1'b0, "96");
        finishLoad(8'h96, "96");

`ifndef SC_REGSERIALIN_PARITY_EN
        // Valid bits in IDLE after a load change nothing.
        for (int i = 0; i < 10; i++) begin
            serialBus.SC_RegSERIALIN_serial_In       = i[0];
            serialBus.SC_RegSERIALIN_bitValid_InHigh = 1'b1;
            step();
            checkOutputs("idleValid", 8'h96, 1'b1, 1'b0, 1'b0);
        end
        serialBus.SC_RegSERIALIN_bitValid_InHigh = 1'b0;
`endif

        // 0x5A loaded, then reset five bits into the next frame.
        doStart("5a");
        sendFrameBits(8'h5A, 1'b0, "5a");
        finishLoad(8'h5A, "5a");
        doStart("abort");
        sendBits(8'hFF, 5, 1'b0, 1'b0, "abort");
        #2 rstN = 1'b0;
        #1 checkOutputs("abortReset", 8'h00, 1'b1, 1'b0, 1'b0);
        step();
        rstN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            serialBus.SC_RegSERIALIN_serial_In       = 1'b1;
            serialBus.SC_RegSERIALIN_bitValid_InHigh = 1'b1;
            step();
            checkOutputs("postAbort", 8'h00, 1'b1, 1'b0, 1'b0);
        end
        serialBus.SC_RegSERIALIN_bitValid_InHigh = 1'b0;

`ifdef SC_REGSERIALIN_PARITY_EN
        // 0x07 with correct parity (1) loads; with parity 0 it is rejected and flagged.
        doStart("parOk");
        sendBits(8'h07, W, 1'b0, 1'b0, "parOk");
        sendBits(8'h01, 1, 1'b0, 1'b1, "parOkBit");
        finishLoad(8'h07, "parOk");
        doStart("parBad");
        sendBits(8'h07, W, 1'b0, 1'b0, "parBad");
        serialBus.SC_RegSERIALIN_serial_In       = 1'b0;
        serialBus.SC_RegSERIALIN_bitValid_InHigh = 1'b1;
        step();
        serialBus.SC_RegSERIALIN_bitValid_InHigh = 1'b0;
        checkOutputs("parBadCycle", 8'h07, 1'b1, 1'b0, 1'b1);
        step();
        checkOutputs("parBadSticky", 8'h07, 1'b1, 1'b0, 1'b1);
        doStart("parClear");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
